cache_mem_arbiter: RTL and testbench

- Shares the single cacheline-wide physical memory port between the instruction cache and the data cache.
- Sits between the two cache controllers' memory-side handshakes (read/write request held until a one-cycle response) and the cacheline adaptor.
- Grants one requester at a time, latches that requester's address and write data, and forwards the memory response only to the granted requester.

---
 rtl/cache_mem_arbiter.sv | 111 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares the cacheline memory port between the I-cache and D-cache, one owner at a time.
// Build option: define CACHE_ARB_RR_EN for round-robin idle arbitration (default: D over I).
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic OwnerI = 1'b0;
    localparam logic OwnerD = 1'b1;

    state_e            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic req_i;
    logic req_d;
    logic pick_d;
    logic busy;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
    // On contention the side that did not win the previous grant goes first.
    assign pick_d = req_d & (~req_i | (last_grant_q == OwnerI));
`else
    assign pick_d = req_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnerI;
            last_grant_q <= OwnerI;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_i || req_d) begin
                        state_q      <= pick_d ? StBusyD : StBusyI;
                        owner_q      <= pick_d;
                        last_grant_q <= pick_d;
                        mem_addr_q   <= pick_d ? d_addr : i_addr;
                        // A write request always takes precedence over a read from the D side.
                        mem_read_q   <= ~(pick_d & d_write);
                        mem_write_q  <= pick_d & d_write;
                        if (pick_d && d_write) begin
                            mem_wdata_q <= d_wdata;
                        end
                    end
                end
                StBusyI, StBusyD: begin
                    if (mem_resp) begin
                        state_q     <= StIdle;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign i_resp    = busy & mem_resp & (owner_q == OwnerI);
    assign d_resp    = busy & mem_resp & (owner_q == OwnerD);
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
            assert (state_q == StIdle ||
                    ((owner_q == (state_q == StBusyD)) && (last_grant_q == owner_q)));
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: I/D cache drivers, an adaptor model and a monitor
// that checks grants, latched requests and response routing against a reference memory.
module tb_cache_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_resp;
    logic [LW-1:0] mem_rdata;

    cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_resp    (i_resp),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_resp    (d_resp),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } sb_t;

    sb_t           exp_i[$];
    sb_t           exp_d[$];
    logic [LW-1:0] rmem[logic [AW-1:0]];
    logic [LW-1:0] amem[logic [AW-1:0]];

    int            checks = 0;
    int            failures = 0;
    int            force_lat = -1;
    bit            stray_req = 1'b0;
    bit            mon_en = 1'b0;
    logic [AW-1:0] pend_i_addr = '0;
    logic [AW-1:0] pend_d_addr = '0;
    logic          pend_d_write = 1'b0;
    logic [LW-1:0] pend_d_wdata = '0;

    function automatic logic [LW-1:0] line_init(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LW-1:0] rmem_get(input logic [AW-1:0] a);
        if (rmem.exists(a)) return rmem[a];
        return line_init(a);
    endfunction

    function automatic logic [LW-1:0] amem_get(input logic [AW-1:0] a);
        if (amem.exists(a)) return amem[a];
        return line_init(a);
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // I-cache driver: hold i_read until i_resp, optionally disturb i_addr once granted.
    task automatic i_txn(input logic [AW-1:0] addr, input bit scramble);
        int n = 0;
        bit seen = 1'b0;
        bit acted = 1'b0;
        exp_i.push_back(sb_t'{1'b0, addr, rmem_get(addr)});
        pend_i_addr = addr;
        i_addr = addr;
        i_read = 1'b1;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (i_resp) begin
                seen = 1'b1;
            end else if (scramble && !acted && mem_read && !mem_addr[AW-1]) begin
                acted = 1'b1;
                @(posedge clk);
                #1;
                i_addr = 32'h0000_1000 | ($urandom & 32'h0000_0FE0);
            end
        end
        check("i_resp_seen", 256'(seen), 256'(1'b1));
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    // D-cache driver: optionally disturb inputs or drop the request once granted.
    task automatic d_txn(input bit write, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                         input bit scramble, input bit drop);
        int n = 0;
        bit seen = 1'b0;
        bit acted = 1'b0;
        if (write) begin
            rmem[addr] = data;
            exp_d.push_back(sb_t'{1'b1, addr, data});
        end else begin
            exp_d.push_back(sb_t'{1'b0, addr, rmem_get(addr)});
        end
        pend_d_addr = addr;
        pend_d_write = write;
        pend_d_wdata = data;
        d_addr = addr;
        d_wdata = data;
        d_write = write;
        d_read = ~write;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (d_resp) begin
                seen = 1'b1;
            end else if ((scramble || drop) && !acted && (mem_read || mem_write) &&
                         mem_addr[AW-1]) begin
                acted = 1'b1;
                @(posedge clk);
                #1;
                if (scramble) begin
                    d_addr = 32'hDEAD_BEE0;
                    d_wdata = rand_line();
                end
                if (drop) begin
                    d_read = 1'b0;
                    d_write = 1'b0;
                end
            end
        end
        check("d_resp_seen", 256'(seen), 256'(1'b1));
        @(posedge clk);
        #1;
        d_read = 1'b0;
        d_write = 1'b0;
    endtask

    // Adaptor model: variable latency, backing memory, occasional stray mem_resp while idle.
    initial begin
        bit a_busy;
        int a_cnt;
        a_busy = 1'b0;
        a_cnt = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            mem_rdata = rand_line();
            if (rst) begin
                a_busy = 1'b0;
            end else begin
                if (!a_busy && (mem_read || mem_write)) begin
                    a_busy = 1'b1;
                    a_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                end else if (a_busy) begin
                    a_cnt--;
                end
                if (a_busy && a_cnt == 0) begin
                    mem_resp = 1'b1;
                    if (mem_write) amem[mem_addr] = mem_wdata;
                    else mem_rdata = amem_get(mem_addr);
                    a_busy = 1'b0;
                end else if (!a_busy && !(mem_read || mem_write) &&
                             (stray_req || $urandom_range(0, 9) == 0)) begin
                    mem_resp = 1'b1;
                    stray_req = 1'b0;
                end
            end
        end
    end

    // Monitor: tracks idle/busy from observed traffic and pops the scoreboard on responses.
    bit            mon_busy = 1'b0;
    bit            mon_decide = 1'b0;
    bit            dec_i = 1'b0;
    bit            dec_d = 1'b0;
    bit            last_owner = 1'b0;
    bit            cur_owner = 1'b0;
    bit            cur_write = 1'b0;
    bit            m_on;
    bit            exp_owner;
    logic [AW-1:0] cur_addr = '0;
    logic [LW-1:0] cur_wdata = '0;
    sb_t           m_e;

    always @(negedge clk) begin
        if (!mon_en) begin
            mon_busy = 1'b0;
            mon_decide = 1'b0;
            last_owner = 1'b0;
        end else begin
            check("i_rdata_pass", i_rdata, mem_rdata);
            check("d_rdata_pass", d_rdata, mem_rdata);
            m_on = mem_read | mem_write;
            if (!mon_busy) begin
                if (mon_decide) begin
                    check("grant_latency", 256'(m_on), 256'(1'b1));
                    if (m_on) begin
                        exp_owner = dec_d;
`ifdef CACHE_ARB_RR_EN
                        if (dec_i && dec_d) exp_owner = ~last_owner;
`endif
                        check("grant_owner", 256'(mem_write | mem_addr[AW-1]), 256'(exp_owner));
                        cur_owner = exp_owner;
                        last_owner = exp_owner;
                        cur_write = exp_owner & pend_d_write;
                        cur_addr = exp_owner ? pend_d_addr : pend_i_addr;
                        cur_wdata = pend_d_wdata;
                        mon_busy = 1'b1;
                    end
                end else begin
                    check("no_spurious_grant", 256'(m_on), 256'(1'b0));
                end
            end
            mon_decide = 1'b0;
            if (mon_busy) begin
                check("mem_op", 256'({mem_read, mem_write}), 256'({~cur_write, cur_write}));
                check("mem_addr", 256'(mem_addr), 256'(cur_addr));
                if (cur_write) check("mem_wdata", mem_wdata, cur_wdata);
                if (mem_resp) begin
                    check("resp_route", 256'({i_resp, d_resp}),
                          256'(cur_owner ? 2'b01 : 2'b10));
                    if (cur_owner) begin
                        check("d_sb_nonempty", 256'(exp_d.size() != 0), 256'(1'b1));
                        if (exp_d.size() != 0) begin
                            m_e = exp_d.pop_front();
                            check("d_sb_addr", 256'(m_e.addr), 256'(cur_addr));
                            if (!m_e.w) check("d_rdata", d_rdata, m_e.data);
                        end
                    end else begin
                        check("i_sb_nonempty", 256'(exp_i.size() != 0), 256'(1'b1));
                        if (exp_i.size() != 0) begin
                            m_e = exp_i.pop_front();
                            check("i_sb_addr", 256'(m_e.addr), 256'(cur_addr));
                            check("i_rdata", i_rdata, m_e.data);
                        end
                    end
                    mon_busy = 1'b0;
                end else begin
                    check("resp_quiet", 256'({i_resp, d_resp}), 256'(2'b00));
                end
            end else begin
                check("idle_no_resp", 256'({i_resp, d_resp}), 256'(2'b00));
                dec_i = i_read;
                dec_d = d_read | d_write;
                mon_decide = i_read | d_read | d_write;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        i_read = 1'b0;
        i_addr = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_mem_req", 256'({mem_read, mem_write}), 256'(2'b00));
        check("reset_resp", 256'({i_resp, d_resp}), 256'(2'b00));
        check("reset_mem_addr", 256'(mem_addr), 256'(32'h0));
        check("reset_mem_wdata", mem_wdata, 256'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        fork
            begin
                repeat (60) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    i_txn(32'h0000_1000 | ($urandom & 32'h0000_0FE0), 1'($urandom_range(0, 1)));
                end
            end
            begin
                repeat (60) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    d_txn(1'($urandom_range(0, 1)),
                          32'h8000_0000 | ($urandom_range(0, 7) << 5), rand_line(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                end
            end
        join

        // Single I read with fixed adaptor latency and known line.
        rmem[32'h0000_1040] = {32{8'hA5}};
        amem[32'h0000_1040] = {32{8'hA5}};
        force_lat = 3;
        i_txn(32'h0000_1040, 1'b0);
        force_lat = -1;

        // Write-back then refill, then read the written line back.
        d_txn(1'b1, 32'h8000_0000, {8{32'h1234_5678}}, 1'b0, 1'b0);
        d_txn(1'b0, 32'h8000_0100, rand_line(), 1'b0, 1'b0);
        d_txn(1'b0, 32'h8000_0000, rand_line(), 1'b0, 1'b0);

        // Contention right after a D grant.
        d_txn(1'b0, 32'h8000_0020, rand_line(), 1'b0, 1'b0);
        fork
            i_txn(32'h0000_1080, 1'b0);
            d_txn(1'b0, 32'h8000_0040, rand_line(), 1'b0, 1'b0);
        join

        // Inputs changed and request dropped mid-transfer.
        force_lat = 3;
        d_txn(1'b0, 32'h8000_0060, rand_line(), 1'b1, 1'b1);
        d_txn(1'b1, 32'h8000_0060, rand_line(), 1'b1, 1'b0);
        d_txn(1'b0, 32'h8000_0060, rand_line(), 1'b0, 1'b0);
        force_lat = -1;

        // Asynchronous reset during an I transfer.
        force_lat = 20;
        pend_i_addr = 32'h0000_1200;
        i_addr = 32'h0000_1200;
        i_read = 1'b1;
        n = 0;
        while (!mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_grant", 256'(mem_read), 256'(1'b1));
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_mem_req", 256'({mem_read, mem_write}), 256'(2'b00));
        check("rst_async_resp", 256'({i_resp, d_resp}), 256'(2'b00));
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_mem_req", 256'({mem_read, mem_write}), 256'(2'b00));
        check("post_rst_resp", 256'({i_resp, d_resp}), 256'(2'b00));
        check("post_rst_mem_addr", 256'(mem_addr), 256'(32'h0));
        check("post_rst_mem_wdata", mem_wdata, 256'(0));
        force_lat = -1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        i_txn(32'h0000_1140, 1'b0);

        // Stray mem_resp while idle must be ignored.
        stray_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_idle", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(4'b0000));
        end
        @(posedge clk);
        #1;
        i_txn(32'h0000_1180, 1'b0);
        d_txn(1'b0, 32'h8000_0020, rand_line(), 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_drained", 256'(exp_i.size() + exp_d.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
